tft_pic_pingpong: RTL

- Parametrised picture-overlay engine for the TFT path.
- A byte stream (e.g. from the UART receiver) loads an IMG_W x IMG_H image into the back bank of a ping-pong RAM.
- The display bank is swapped in only at frame sync, so the screen never tears.
- During display, the image is overlaid on a colour-bar or solid background at a runtime-programmable position, with optional colour-key transparency.
- Sits between the UART receiver and the TFT timing controller; single clock domain, sys_clk.

---
 rtl/tft_pkg.sv | 22 ++
 rtl/tft_pic_pingpong_if.sv | 37 +++
 rtl/pic_bank_ram.sv | 34 +++
 rtl/tft_pic_pingpong.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tft_pkg
// Brief    : Shared constants and helpers for the TFT picture overlay path.
// Revision : 1.0 - initial release
// ============================================================================
package tft_pkg;

    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] GREEN = 8'h1C;
    localparam logic [7:0] BLUE  = 8'h03;
    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] WHITE = 8'hFF;

    localparam int BAR_CNT = 5;

    function automatic int bank_depth(input int w, input int h);
        return w * h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tft_pic_pingpong_if.sv
`default_nettype none
// ============================================================================
// Module   : tft_pic_pingpong_if
// Brief    : Load stream, pixel timing and overlay output bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface tft_pic_pingpong_if #(
    parameter int DW = 8
);
    logic          pi_flag;
    logic [DW-1:0] pi_data;
    logic          frame_sync;
    logic          pix_en;
    logic [9:0]    pix_x;
    logic [9:0]    pix_y;
    logic [9:0]    pos_x;
    logic [9:0]    pos_y;
    logic          bg_mode;
    logic [DW-1:0] bg_color;
    logic [DW-1:0] pix_data;
    logic          buf_sel;
    logic          load_done;
    logic          err_timeout;

    modport master (
        output pi_flag, pi_data, frame_sync, pix_en, pix_x, pix_y,
               pos_x, pos_y, bg_mode, bg_color,
        input  pix_data, buf_sel, load_done, err_timeout
    );

    modport slave (
        input  pi_flag, pi_data, frame_sync, pix_en, pix_x, pix_y,
               pos_x, pos_y, bg_mode, bg_color,
        output pix_data, buf_sel, load_done, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/pic_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : pic_bank_ram
// Brief    : Simple dual-port RAM, one write port, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module pic_bank_ram #(
    parameter int DW     = 8,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 10000
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DW-1:0]     i_wdata,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DW-1:0]     o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/tft_pic_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : tft_pic_pingpong
// Brief    : Ping-pong image buffer overlaid on colour bars / solid background.
// Revision : 1.0 - initial release
// ============================================================================
module tft_pic_pingpong
    import tft_pkg::*;
#(
    parameter int H_VALID   = 480,
    parameter int V_VALID   = 272,
    parameter int IMG_W     = 100,
    parameter int IMG_H     = 100,
    parameter int DW        = 8,
    parameter int ADDR_W    = 14,
    parameter int TIMEOUT   = 50000,
    parameter int KEY_EN    = 0,
    parameter int KEY_COLOR = 0
) (
    input  wire logic           sys_clk,
    input  wire logic           sys_rst_n,
    tft_pic_pingpong_if.slave   bus
);
    localparam int c_depth = bank_depth(IMG_W, IMG_H);
    localparam int c_to_w  = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] c_last    = ADDR_W'(c_depth - 1);
    localparam logic [ADDR_W-1:0] c_img_w_a = ADDR_W'(IMG_W);
    localparam logic [c_to_w-1:0] c_to_max  = c_to_w'(TIMEOUT);
    localparam logic [c_to_w-1:0] c_to_m1   = c_to_w'(TIMEOUT - 1);
    localparam logic [10:0]       c_img_w11 = 11'(IMG_W);
    localparam logic [10:0]       c_img_h11 = 11'(IMG_H);
    localparam logic [10:0]       c_h_valid = 11'(H_VALID);
    localparam logic [10:0]       c_v_valid = 11'(V_VALID);
    localparam logic [10:0]       c_bar_w   = 11'(H_VALID / BAR_CNT);
    localparam logic [9:0]        c_px_rst  = 10'((H_VALID - IMG_W) / 2);
    localparam logic [9:0]        c_py_rst  = 10'((V_VALID - IMG_H) / 2);

    if ((1 << ADDR_W) < c_depth) begin : g_depth_err
        $error("ADDR_W too small for IMG_W*IMG_H");
    end

    logic [ADDR_W-1:0] r_wr_addr;
    logic [c_to_w-1:0] r_idle;
    logic              r_swap_pending;
    logic              r_buf_sel;
    logic              r_load_done;
    logic              r_err_timeout;
    logic [9:0]        r_px;
    logic [9:0]        r_py;
    logic              r_win_d;
    logic              r_rd_sel;
    logic [DW-1:0]     r_bg_d;

    logic              w_wrap;
    logic              w_timeout;
    logic              w_in_win;
    logic [10:0]       w_x;
    logic [10:0]       w_y;
    logic [10:0]       w_px;
    logic [10:0]       w_py;
    logic [9:0]        w_dx;
    logic [9:0]        w_dy;
    logic [ADDR_W-1:0] w_raddr;
    logic [DW-1:0]     w_bar;
    logic [DW-1:0]     w_bg;
    logic [DW-1:0]     w_q;
    logic              w_key_hit;
    logic [DW-1:0]     w_q_bank [2];

    assign w_wrap    = bus.pi_flag && (r_wr_addr == c_last);
    assign w_timeout = !bus.pi_flag && (r_wr_addr != '0) && (r_idle >= c_to_m1);

    // Load side: write pointer, idle watchdog and completion/timeout pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_addr     <= '0;
            r_idle        <= '0;
            r_load_done   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_load_done   <= w_wrap;
            r_err_timeout <= w_timeout;
            if (bus.pi_flag) begin
                r_idle    <= '0;
                r_wr_addr <= w_wrap ? '0 : r_wr_addr + 1'b1;
            end else begin
                if (r_idle != c_to_max) begin
                    r_idle <= r_idle + 1'b1;
                end
                if (w_timeout) begin
                    r_wr_addr <= '0;
                end
            end
        end
    end

    // A load finishing on the frame_sync cycle sets pending and defers the swap.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_swap_pending <= 1'b0;
            r_buf_sel      <= 1'b0;
            r_px           <= c_px_rst;
            r_py           <= c_py_rst;
        end else begin
            if (bus.frame_sync) begin
                r_px <= bus.pos_x;
                r_py <= bus.pos_y;
                if (r_swap_pending) begin
                    r_buf_sel <= ~r_buf_sel;
                end
            end
            if (w_wrap) begin
                r_swap_pending <= 1'b1;
            end else if (bus.frame_sync) begin
                r_swap_pending <= 1'b0;
            end
        end
    end

    assign w_x  = {1'b0, bus.pix_x};
    assign w_y  = {1'b0, bus.pix_y};
    assign w_px = {1'b0, r_px};
    assign w_py = {1'b0, r_py};

    assign w_in_win = bus.pix_en
                   && (w_x >= w_px) && (w_x < w_px + c_img_w11)
                   && (w_y >= w_py) && (w_y < w_py + c_img_h11)
                   && (w_x < c_h_valid) && (w_y < c_v_valid);

    // Address derived from the pixel position so clipped rows stay aligned.
    assign w_dx    = bus.pix_x - r_px;
    assign w_dy    = bus.pix_y - r_py;
    assign w_raddr = ADDR_W'(w_dy) * c_img_w_a + ADDR_W'(w_dx);

    always_comb begin
        w_bar = DW'(BLACK);
        if (w_x < c_bar_w) begin
            w_bar = DW'(RED);
        end else if (w_x < 11'(2) * c_bar_w) begin
            w_bar = DW'(GREEN);
        end else if (w_x < 11'(3) * c_bar_w) begin
            w_bar = DW'(BLUE);
        end else if (w_x < 11'(4) * c_bar_w) begin
            w_bar = DW'(BLACK);
        end else if (w_x < 11'(5) * c_bar_w) begin
            w_bar = DW'(WHITE);
        end
    end

    assign w_bg = bus.bg_mode ? bus.bg_color : w_bar;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pic_bank_ram #(
            .DW     (DW),
            .ADDR_W (ADDR_W),
            .DEPTH  (c_depth)
        ) u_ram (
            .clk     (sys_clk),
            .i_we    (bus.pi_flag && (r_buf_sel != 1'(b))),
            .i_waddr (r_wr_addr),
            .i_wdata (bus.pi_data),
            .i_re    (w_in_win && (r_buf_sel == 1'(b))),
            .i_raddr (w_raddr),
            .o_rdata (w_q_bank[b])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_win_d  <= 1'b0;
            r_rd_sel <= 1'b0;
            r_bg_d   <= '0;
        end else begin
            r_win_d  <= w_in_win;
            r_rd_sel <= r_buf_sel;
            r_bg_d   <= w_bg;
        end
    end

    // Bank select is re-timed with the read so a swap cannot split a pixel.
    assign w_q       = w_q_bank[r_rd_sel];
    assign w_key_hit = (KEY_EN != 0) && (w_q == DW'(KEY_COLOR));

    assign bus.pix_data    = (r_win_d && !w_key_hit) ? w_q : r_bg_d;
    assign bus.buf_sel     = r_buf_sel;
    assign bus.load_done   = r_load_done;
    assign bus.err_timeout = r_err_timeout;
endmodule
`default_nettype wire
